// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver state encoding.
// Kept separate so a future transmitter can reuse the same constants.
package uart_rx_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_START = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_STOP  = 5'b01000,
    ST_BREAK = 5'b10000
  } state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Both flops reset to RESET_VAL so an idle-high line shows no edge on reset release.
module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, framing-error detection
// and a BREAK state that waits for the line to return high after a bad stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_FRAME_ERR,
  output logic       RX_BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_frame_err_q, rx_frame_err_d;

  uart_rx_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (UART_RX),
    .q    (rx_s)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  // Shift register contents only matter once a full frame has been assembled.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign RX_DATA      = rx_data_q;
  assign RX_VALID     = rx_valid_q;
  assign RX_FRAME_ERR = rx_frame_err_q;
  assign RX_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized 8N1 frames at 16 clocks/bit, checked against an expected-byte
// queue built from the frames the bench sends.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         long_cnt  = 0;
  logic       prev_v    = 1'b0;
  logic       prev_e    = 1'b0;

  always #5 clock = ~clock;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .UART_RX     (rx_line),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .RX_FRAME_ERR(rx_ferr),
    .RX_BUSY     (rx_busy)
  );

  // Output monitor: record every pulse and any pulse-shape violation.
  always @(negedge clock) begin
    if (rx_valid) obs_q.push_back(rx_data);
    if (rx_ferr) ferr_cnt++;
    if (rx_valid && rx_ferr) both_cnt++;
    if ((rx_valid && prev_v) || (rx_ferr && prev_e)) long_cnt++;
    prev_v = rx_valid;
    prev_e = rx_ferr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference model: a frame with a high stop bit delivers its byte, otherwise nothing.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (rx_busy && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (rx_busy) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int   lat;
    logic done;
    logic [7:0] b;
    int   ferr_base;

    reset     = 1'b1;
    rx_line   = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", rx_ferr, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(4);

    send_frame(8'h55, 1'b1);
    idle(10);
    send_frame(8'hA3, 1'b1);
    idle(10);
    drain("pair");
    chk("pair_data_hold", rx_data, 8'hA3);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    idle(10);
    drain("b2b");

    rx_line = 1'b0;
    repeat (4) @(posedge clock);
    #1 rx_line = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    chk("glitch_busy", rx_busy, 1'b0);
    idle(40);
    chk("glitch_no_valid", obs_q.size(), 0);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(10);
    drain("rand");

    chk("ferr_before", ferr_cnt, 0);
    send_frame(8'h3C, 1'b0);
    rx_line = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    chk("ferr_pulse", ferr_cnt, 1);
    chk("ferr_data_hold", rx_data, last_good);
    chk("ferr_busy_break", rx_busy, 1'b1);
    chk("ferr_no_valid", obs_q.size(), 0);
    idle(CPB);
    send_frame(8'h7E, 1'b1);
    idle(10);
    drain("after_break");
    chk("ferr_single", ferr_cnt, 1);

    ferr_base = ferr_cnt;
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_line = b[4];
    repeat (CPB / 2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_valid", rx_valid, 1'b0);
    chk("midrst_ferr", rx_ferr, 1'b0);
    chk("midrst_busy", rx_busy, 1'b0);
    @(posedge clock);
    #1 rx_line = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle(12 * CPB);
    chk("midrst_no_valid", obs_q.size(), 0);
    chk("midrst_no_ferr", ferr_cnt, ferr_base);
    send_frame(8'h12, 1'b1);
    idle(10);
    drain("post_rst");

    lat  = 0;
    done = 1'b0;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        while (!done && lat < 400) begin
          @(posedge clock);
          #2;
          lat++;
          if (rx_valid) done = 1'b1;
        end
      end
    join
    idle(10);
    chk("latency", lat, 155);
    drain("lat_byte");

    wait_idle("final", 200);
    chk("never_both", both_cnt, 0);
    chk("single_cycle_pulses", long_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
